i2c_txn_arbiter: RTL

- Shares one i2c_master engine between NUM_REQ independent requesters. Each requester wants single-byte I2C read or write transactions.
- Grants round-robin, latches the winner's command and issues one start pulse to the engine.
- Watches for engine completion or a timeout. Returns rdata/nack to the winner only. Aborts a hung engine via its state_reset input.
- Sits between on-chip requesters (config sequencers, sensor pollers) and the i2c_master that drives sda/scl.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/i2c_txn_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C widths, direction codes and arbiter state encoding
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4,
        ST_ABORT = 3'd5
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first set req at or after ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    int pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (!valid && req[pos]) begin
                valid    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - shares one i2c_master between NUM_REQ requesters
// with round-robin grant, command latching, timeout and engine abort.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int ABORT_CYC   = 4
) (
    input  logic                             clk_50,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0]    req_addr,
    input  logic [NUM_REQ-1:0]               req_rw,
    input  logic [I2C_DATA_W*NUM_REQ-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [I2C_DATA_W-1:0]            rsp_rdata,
    output logic                             rsp_nack,
    output logic                             rsp_timeout,
    output logic [NUM_REQ-1:0]               gnt,
    output logic                             m_start,
    output logic [I2C_ADDR_W-1:0]            m_addr,
    output logic                             m_rw,
    output logic [I2C_DATA_W-1:0]            m_wdata,
    output logic                             m_state_reset,
    input  logic                             m_busy,
    input  logic                             m_done,
    input  logic [I2C_DATA_W-1:0]            m_rdata,
    input  logic                             m_nack
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam int AB_W  = $clog2(ABORT_CYC + 1);

    state_t state, state_d;

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      win_idx;
    logic [CNT_W-1:0]      tmo_cnt;
    logic [AB_W-1:0]       ab_cnt;

    logic [NUM_REQ-1:0]    pick_gnt;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;

    logic [I2C_ADDR_W-1:0] sel_addr;
    logic                  sel_rw;
    logic [I2C_DATA_W-1:0] sel_wdata;

    logic req_held;
    logic tmo_hit;
    logic ab_last;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Slice mux driven by the one-hot pick; the command is frozen in ARB.
    always_comb begin
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_addr  = req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
                sel_rw    = req_rw[i];
                sel_wdata = req_wdata[i*I2C_DATA_W +: I2C_DATA_W];
            end
        end
    end

    assign req_held = |(req & gnt);
    assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign ab_last  = (ab_cnt == AB_W'(ABORT_CYC - 1));

    always_comb begin
        state_d       = state;
        m_start       = 1'b0;
        m_state_reset = 1'b1;
        rsp_valid     = '0;
        case (state)
            ST_IDLE: begin
                if (|req && !m_busy) state_d = ST_ARB;
            end
            ST_ARB: begin
                state_d = pick_valid ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                // A requester that withdrew after arbitration is dropped silently.
                if (req_held) begin
                    m_start = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (m_done)       state_d = ST_RESP;
                else if (tmo_hit) state_d = ST_ABORT;
            end
            ST_ABORT: begin
                m_state_reset = 1'b0;
                if (ab_last) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = gnt;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            win_idx     <= '0;
            tmo_cnt     <= '0;
            ab_cnt      <= '0;
            gnt         <= '0;
            m_addr      <= '0;
            m_rw        <= 1'b0;
            m_wdata     <= '0;
            rsp_rdata   <= '0;
            rsp_nack    <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                ST_ARB: begin
                    if (pick_valid) begin
                        gnt     <= pick_gnt;
                        win_idx <= pick_idx;
                        m_addr  <= sel_addr;
                        m_rw    <= sel_rw;
                        m_wdata <= sel_wdata;
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt <= '0;
                    if (!req_held) gnt <= '0;
                end
                ST_WAIT: begin
                    ab_cnt <= '0;
                    if (tmo_cnt != {CNT_W{1'b1}}) tmo_cnt <= tmo_cnt + CNT_W'(1);
                    // m_done is checked first so a completion on the last cycle wins.
                    if (m_done) begin
                        rsp_rdata   <= m_rdata;
                        rsp_nack    <= m_nack;
                        rsp_timeout <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_rdata   <= '0;
                        rsp_nack    <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end
                end
                ST_ABORT: begin
                    ab_cnt <= ab_cnt + AB_W'(1);
                end
                ST_RESP: begin
                    gnt    <= '0;
                    rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
